// File: rtl/riscv_pkg.sv
// riscv_pkg
//   Shared encodings for the ALU issue stage: 4-bit ALUop codes, RV32I
//   major opcodes, funct3/funct7 codes, the registered issue bundle and a
//   helper that maps a register/immediate funct3 onto its base ALUop.
//   No ports.
package riscv_pkg;

  // ALU operation encoding (consumed by the combinational ALU)
  localparam logic [3:0] ALUOP_AND  = 4'd0;
  localparam logic [3:0] ALUOP_OR   = 4'd1;
  localparam logic [3:0] ALUOP_ADD  = 4'd2;
  localparam logic [3:0] ALUOP_XOR  = 4'd3;
  localparam logic [3:0] ALUOP_SLL  = 4'd4;
  localparam logic [3:0] ALUOP_SRL  = 4'd5;
  localparam logic [3:0] ALUOP_SUB  = 4'd6;
  localparam logic [3:0] ALUOP_SLTU = 4'd7;
  localparam logic [3:0] ALUOP_SLE  = 4'd8;
  localparam logic [3:0] ALUOP_SRA  = 4'd9;

  // RV32I major opcodes
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // funct3 for OP / OP-IMM
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // funct3 for BRANCH
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // funct7 values that select the base / alternate operation
  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  // Everything the stage holds for one issued op
  typedef struct packed {
    logic [3:0]  alu_op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        rd_we;
    logic        res_inv;
    logic        is_branch;
    logic        br_on_zero;
    logic        illegal;
  } issue_t;

  // Base (funct7 == 0) ALUop for a given funct3. SLT maps to SLE because
  // the decoder swaps the operands and inverts the result.
  function automatic logic [3:0] base_alu_op(input logic [2:0] f3);
    logic [3:0] op;
    case (f3)
      F3_ADD:  op = ALUOP_ADD;
      F3_SLL:  op = ALUOP_SLL;
      F3_SLT:  op = ALUOP_SLE;
      F3_SLTU: op = ALUOP_SLTU;
      F3_XOR:  op = ALUOP_XOR;
      F3_SR:   op = ALUOP_SRL;
      F3_OR:   op = ALUOP_OR;
      F3_AND:  op = ALUOP_AND;
      default: op = ALUOP_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// alu_issue_stage_if
//   Issue-side bundle between the ALU issue stage (master) and the EX stage
//   (slave): valid/ready handshake plus ALUop, operands, PC, writeback and
//   branch qualifiers.
//   Signals: out_valid, out_ready, alu_op[3:0], alu_a[31:0], alu_b[31:0],
//            out_pc[31:0], rd_addr[4:0], rd_we, res_inv, is_branch,
//            br_on_zero, illegal.
interface alu_issue_stage_if;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] out_pc;
  logic [4:0]  rd_addr;
  logic        rd_we;
  logic        res_inv;
  logic        is_branch;
  logic        br_on_zero;
  logic        illegal;

  modport master (
    output out_valid, alu_op, alu_a, alu_b, out_pc, rd_addr, rd_we,
           res_inv, is_branch, br_on_zero, illegal,
    input  out_ready
  );

  modport slave (
    input  out_valid, alu_op, alu_a, alu_b, out_pc, rd_addr, rd_we,
           res_inv, is_branch, br_on_zero, illegal,
    output out_ready
  );
endinterface

// File: rtl/imm_gen.sv
// imm_gen
//   Combinational immediate extraction for RV32I I/S/U formats; I and S
//   immediates are sign-extended, U is placed in the upper 20 bits.
//   Ports: instr[31:0] in; imm_i, imm_s, imm_u [31:0] out.
module imm_gen (
  input  logic [31:0] instr,
  output logic [31:0] imm_i,
  output logic [31:0] imm_s,
  output logic [31:0] imm_u
);
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u = {instr[31:12], 12'h000};
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   Decodes one RV32I instruction plus its register operands into an ALUop,
//   operands A/B and writeback/branch qualifiers, held in a single
//   registered stage with a valid/ready handshake toward the ALU.
//   Ports: clk, rst_n (async active-low), flush;
//          in_valid/in_ready, in_instr, in_pc, rs1_data, rs2_data (upstream);
//          out_if (master modport of alu_issue_stage_if, toward EX).
module alu_issue_stage
  import riscv_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  alu_issue_stage_if.master out_if
);

  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_u;

  imm_gen u_imm_gen (
    .instr (in_instr),
    .imm_i (imm_i),
    .imm_s (imm_s),
    .imm_u (imm_u)
  );

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd_f;
  logic [31:0] shamt;

  assign opcode = in_instr[6:0];
  assign rd_f   = in_instr[11:7];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign shamt  = {27'd0, in_instr[24:20]};

  issue_t dec;
  logic   legal;
  logic   writes_rd;

  // Instruction decode into the issue bundle
  always_comb begin
    dec            = '0;
    dec.alu_op     = ALUOP_ADD;
    dec.a          = rs1_data;
    dec.b          = rs2_data;
    dec.pc         = in_pc;
    dec.rd         = rd_f;
    legal          = 1'b1;
    writes_rd      = 1'b0;
    case (opcode)
      OPC_OP: begin
        writes_rd  = 1'b1;
        dec.alu_op = base_alu_op(funct3);
        if (funct7 == F7_BASE) begin
          if (funct3 == F3_SLT) begin
            // rs1 < rs2 signed  ==  !(rs2 <= rs1)
            dec.a       = rs2_data;
            dec.b       = rs1_data;
            dec.res_inv = 1'b1;
          end else begin
            dec.res_inv = 1'b0;
          end
        end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
          dec.alu_op = ALUOP_SUB;
        end else if (funct7 == F7_ALT && funct3 == F3_SR) begin
          dec.alu_op = ALUOP_SRA;
        end else begin
          legal = 1'b0;
        end
      end
      OPC_OP_IMM: begin
        writes_rd  = 1'b1;
        dec.alu_op = base_alu_op(funct3);
        dec.b      = imm_i;
        case (funct3)
          F3_SLT: begin
            dec.a       = imm_i;
            dec.b       = rs1_data;
            dec.res_inv = 1'b1;
          end
          F3_SLL: begin
            dec.b = shamt;
            if (funct7 != F7_BASE) begin
              legal = 1'b0;
            end else begin
              legal = 1'b1;
            end
          end
          F3_SR: begin
            dec.b = shamt;
            if (funct7 == F7_ALT) begin
              dec.alu_op = ALUOP_SRA;
            end else if (funct7 != F7_BASE) begin
              legal = 1'b0;
            end else begin
              dec.alu_op = ALUOP_SRL;
            end
          end
          default: dec.res_inv = 1'b0;
        endcase
      end
      OPC_LUI: begin
        writes_rd = 1'b1;
        dec.a     = 32'h0000_0000;
        dec.b     = imm_u;
      end
      OPC_AUIPC: begin
        writes_rd = 1'b1;
        dec.a     = in_pc;
        dec.b     = imm_u;
      end
      OPC_LOAD: begin
        writes_rd = 1'b1;
        dec.b     = imm_i;
      end
      OPC_STORE: begin
        dec.b = imm_s;
      end
      OPC_BRANCH: begin
        dec.is_branch = 1'b1;
        case (funct3)
          F3_BEQ: begin
            dec.alu_op     = ALUOP_SUB;
            dec.br_on_zero = 1'b1;
          end
          F3_BNE: begin
            dec.alu_op     = ALUOP_SUB;
            dec.br_on_zero = 1'b0;
          end
          F3_BLT: begin
            // taken iff !(rs2 <= rs1), i.e. SLE result is zero
            dec.alu_op     = ALUOP_SLE;
            dec.a          = rs2_data;
            dec.b          = rs1_data;
            dec.br_on_zero = 1'b1;
          end
          F3_BGE: begin
            dec.alu_op     = ALUOP_SLE;
            dec.a          = rs2_data;
            dec.b          = rs1_data;
            dec.br_on_zero = 1'b0;
          end
          F3_BLTU: begin
            dec.alu_op     = ALUOP_SLTU;
            dec.br_on_zero = 1'b0;
          end
          F3_BGEU: begin
            dec.alu_op     = ALUOP_SLTU;
            dec.br_on_zero = 1'b1;
          end
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase

    // Illegal ops still issue, as a harmless ADD with no side effects
    if (!legal) begin
      dec.alu_op     = ALUOP_ADD;
      dec.res_inv    = 1'b0;
      dec.is_branch  = 1'b0;
      dec.br_on_zero = 1'b0;
    end else begin
      dec.illegal = 1'b0;
    end
    dec.illegal = !legal;
    dec.rd_we   = writes_rd && legal && (rd_f != 5'd0);
  end

  logic   valid_q;
  logic   valid_d;
  issue_t issue_q;
  issue_t issue_d;
  logic   load;

  assign in_ready = !valid_q || out_if.out_ready;
  assign load     = in_valid && in_ready && !flush;

  // Pipe register next-state: flush beats load beats consume
  always_comb begin
    valid_d = valid_q;
    issue_d = issue_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      issue_d = dec;
    end else if (out_if.out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Pipe register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      issue_q    <= '0;
      issue_q.pc <= RESET_PC;
    end else begin
      valid_q <= valid_d;
      issue_q <= issue_d;
    end
  end

  assign out_if.out_valid  = valid_q;
  assign out_if.alu_op     = issue_q.alu_op;
  assign out_if.alu_a      = issue_q.a;
  assign out_if.alu_b      = issue_q.b;
  assign out_if.out_pc     = issue_q.pc;
  assign out_if.rd_addr    = issue_q.rd;
  assign out_if.rd_we      = issue_q.rd_we;
  assign out_if.res_inv    = issue_q.res_inv;
  assign out_if.is_branch  = issue_q.is_branch;
  assign out_if.br_on_zero = issue_q.br_on_zero;
  assign out_if.illegal    = issue_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage
//   Directed self-checking bench for alu_issue_stage: hand-computed
//   expectations for decode, handshake, back-pressure, flush and reset.
module tb_alu_issue_stage;
  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;

  int total;
  int bad;

  alu_issue_stage_if u_if ();

  alu_issue_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_instr (in_instr),
    .in_pc    (in_pc),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .out_if   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [6:0] op);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present one op for one edge, then drop in_valid; outputs sampled 1ns after the edge
  task automatic issue(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b);
    in_instr = instr;
    in_pc    = pc;
    rs1_data = a;
    rs2_data = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    in_instr = 32'h0;
    in_pc    = 32'h0;
    rs1_data = 32'h0;
    rs2_data = 32'h0;
    u_if.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, u_if.out_valid}, 32'd0);
    chk("rst_op", {28'd0, u_if.alu_op}, 32'd0);
    chk("rst_pc", u_if.out_pc, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ADD x3,x1,x2
    issue(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011), 32'h40, 32'd5, 32'd7);
    chk("add_valid", {31'd0, u_if.out_valid}, 32'd1);
    chk("add_op", {28'd0, u_if.alu_op}, 32'd2);
    chk("add_a", u_if.alu_a, 32'd5);
    chk("add_b", u_if.alu_b, 32'd7);
    chk("add_rd", {27'd0, u_if.rd_addr}, 32'd3);
    chk("add_we", {31'd0, u_if.rd_we}, 32'd1);
    chk("add_pc", u_if.out_pc, 32'h40);

    // SUB x5,x1,x2
    issue(enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd5, 7'b0110011), 32'h44, 32'd10, 32'd3);
    chk("sub_op", {28'd0, u_if.alu_op}, 32'd6);
    chk("sub_a", u_if.alu_a, 32'd10);

    // SLT x6,x1,x2 -> operands swapped, result inverted
    issue(enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd6, 7'b0110011), 32'h48, 32'd1, 32'd2);
    chk("slt_op", {28'd0, u_if.alu_op}, 32'd8);
    chk("slt_a", u_if.alu_a, 32'd2);
    chk("slt_b", u_if.alu_b, 32'd1);
    chk("slt_inv", {31'd0, u_if.res_inv}, 32'd1);

    // SRA x7,x1,x2
    issue(enc_r(7'h20, 5'd2, 5'd1, 3'b101, 5'd7, 7'b0110011), 32'h4C, 32'h8000_0000, 32'd4);
    chk("sra_op", {28'd0, u_if.alu_op}, 32'd9);

    // SLTI x4,x1,-1
    issue(enc_i(12'hFFF, 5'd1, 3'b010, 5'd4, 7'b0010011), 32'h50, 32'h8000_0000, 32'd0);
    chk("slti_op", {28'd0, u_if.alu_op}, 32'd8);
    chk("slti_a", u_if.alu_a, 32'hFFFF_FFFF);
    chk("slti_b", u_if.alu_b, 32'h8000_0000);
    chk("slti_inv", {31'd0, u_if.res_inv}, 32'd1);
    chk("slti_we", {31'd0, u_if.rd_we}, 32'd1);

    // SRAI x7,x1,5
    issue(enc_i({7'h20, 5'd5}, 5'd1, 3'b101, 5'd7, 7'b0010011), 32'h54, 32'hF000_0000, 32'd99);
    chk("srai_op", {28'd0, u_if.alu_op}, 32'd9);
    chk("srai_b", u_if.alu_b, 32'd5);

    // SRLI with funct7=0x01 -> illegal
    issue(enc_i({7'h01, 5'd5}, 5'd1, 3'b101, 5'd7, 7'b0010011), 32'h58, 32'd1, 32'd2);
    chk("srli_bad_ill", {31'd0, u_if.illegal}, 32'd1);
    chk("srli_bad_we", {31'd0, u_if.rd_we}, 32'd0);

    // LUI x9,0x12345
    issue({20'h12345, 5'd9, 7'b0110111}, 32'h5C, 32'd11, 32'd12);
    chk("lui_a", u_if.alu_a, 32'd0);
    chk("lui_b", u_if.alu_b, 32'h1234_5000);

    // AUIPC x9,0xFFFFF
    issue({20'hFFFFF, 5'd9, 7'b0010111}, 32'h100, 32'd11, 32'd12);
    chk("auipc_a", u_if.alu_a, 32'h100);
    chk("auipc_b", u_if.alu_b, 32'hFFFF_F000);

    // SW x2,-4(x1)
    issue(enc_s(12'hFFC, 5'd2, 5'd1, 3'b010, 7'b0100011), 32'h104, 32'h1000, 32'hAB);
    chk("sw_op", {28'd0, u_if.alu_op}, 32'd2);
    chk("sw_b", u_if.alu_b, 32'hFFFF_FFFC);
    chk("sw_we", {31'd0, u_if.rd_we}, 32'd0);

    // LW x8,16(x1)
    issue(enc_i(12'd16, 5'd1, 3'b010, 5'd8, 7'b0000011), 32'h108, 32'h2000, 32'd0);
    chk("lw_b", u_if.alu_b, 32'd16);
    chk("lw_we", {31'd0, u_if.rd_we}, 32'd1);

    // BLT rs1=-2 rs2=3
    issue(enc_s(12'd0, 5'd2, 5'd1, 3'b100, 7'b1100011), 32'h10C, 32'hFFFF_FFFE, 32'd3);
    chk("blt_op", {28'd0, u_if.alu_op}, 32'd8);
    chk("blt_a", u_if.alu_a, 32'd3);
    chk("blt_b", u_if.alu_b, 32'hFFFF_FFFE);
    chk("blt_br", {31'd0, u_if.is_branch}, 32'd1);
    chk("blt_boz", {31'd0, u_if.br_on_zero}, 32'd1);
    chk("blt_we", {31'd0, u_if.rd_we}, 32'd0);

    // BGEU
    issue(enc_s(12'd0, 5'd2, 5'd1, 3'b111, 7'b1100011), 32'h110, 32'd4, 32'd9);
    chk("bgeu_op", {28'd0, u_if.alu_op}, 32'd7);
    chk("bgeu_a", u_if.alu_a, 32'd4);
    chk("bgeu_boz", {31'd0, u_if.br_on_zero}, 32'd1);

    // BNE
    issue(enc_s(12'd0, 5'd2, 5'd1, 3'b001, 7'b1100011), 32'h114, 32'd4, 32'd9);
    chk("bne_op", {28'd0, u_if.alu_op}, 32'd6);
    chk("bne_boz", {31'd0, u_if.br_on_zero}, 32'd0);

    // JAL -> illegal, still issued
    issue({20'h00000, 5'd1, 7'h6F}, 32'h118, 32'd0, 32'd0);
    chk("jal_valid", {31'd0, u_if.out_valid}, 32'd1);
    chk("jal_ill", {31'd0, u_if.illegal}, 32'd1);
    chk("jal_we", {31'd0, u_if.rd_we}, 32'd0);
    chk("jal_op", {28'd0, u_if.alu_op}, 32'd2);

    // OP funct7=0x01 -> illegal
    issue(enc_r(7'h01, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011), 32'h11C, 32'd1, 32'd2);
    chk("op_f7_ill", {31'd0, u_if.illegal}, 32'd1);
    chk("op_f7_we", {31'd0, u_if.rd_we}, 32'd0);

    // ADD x0 -> no writeback
    issue(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd0, 7'b0110011), 32'h120, 32'd1, 32'd2);
    chk("x0_we", {31'd0, u_if.rd_we}, 32'd0);
    chk("x0_ill", {31'd0, u_if.illegal}, 32'd0);

    // Consume without new load
    @(posedge clk);
    #1;
    chk("drain_valid", {31'd0, u_if.out_valid}, 32'd0);

    // Back-pressure: op A held 3 cycles while op B waits
    issue(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011), 32'h200, 32'd5, 32'd7);
    u_if.out_ready = 1'b0;
    in_instr = enc_r(7'h00, 5'd2, 5'd1, 3'b100, 5'd4, 7'b0110011);
    in_pc    = 32'h204;
    rs1_data = 32'hF0;
    rs2_data = 32'h0F;
    in_valid = 1'b1;
    #1;
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_valid", {31'd0, u_if.out_valid}, 32'd1);
      chk("bp_hold_op", {28'd0, u_if.alu_op}, 32'd2);
      chk("bp_hold_a", u_if.alu_a, 32'd5);
      chk("bp_hold_pc", u_if.out_pc, 32'h200);
      chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
    end
    u_if.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_b_valid", {31'd0, u_if.out_valid}, 32'd1);
    chk("bp_b_op", {28'd0, u_if.alu_op}, 32'd3);
    chk("bp_b_a", u_if.alu_a, 32'hF0);
    chk("bp_b_pc", u_if.out_pc, 32'h204);
    @(posedge clk);
    #1;
    chk("bp_drain", {31'd0, u_if.out_valid}, 32'd0);

    // Flush while an op is held and another arrives
    issue(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011), 32'h300, 32'd5, 32'd7);
    u_if.out_ready = 1'b0;
    in_instr = enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd5, 7'b0110011);
    in_pc    = 32'h304;
    rs1_data = 32'd1;
    rs2_data = 32'd2;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", {31'd0, u_if.out_valid}, 32'd0);
    u_if.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("flush_no_ghost", {31'd0, u_if.out_valid}, 32'd0);

    // Asynchronous reset during hold
    issue(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011), 32'h400, 32'd5, 32'd7);
    u_if.out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("rh_held", {31'd0, u_if.out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rh_valid", {31'd0, u_if.out_valid}, 32'd0);
    chk("rh_a", u_if.alu_a, 32'd0);
    chk("rh_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    u_if.out_ready = 1'b1;
    @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
